// File: rtl/game_set_if.sv
// Settings path between the settings producer (master) and the downstream latch (slave).
interface game_set_if;
  logic [4:0]  button_num;
  logic [6:0]  button_size;
  logic [9:0]  board_size;
  logic [10:0] board_xpos;
  logic [10:0] board_ypos;

  modport master (
    output button_num, button_size, board_size, board_xpos, board_ypos
  );

  modport slave (
    input button_num, button_size, board_size, board_xpos, board_ypos
  );
endinterface

// File: rtl/settings_gen.sv
// settings_gen: turns a difficulty request into a centred board geometry using a
// 7-step shift-add multiplier, then publishes it with a one-cycle settings_valid strobe.
// Optional feature macro: SETTINGS_CUSTOM_EN (custom num/size requests with error strobe).
module settings_gen #(
  parameter int unsigned H_RES = 1024,
  parameter int unsigned V_RES = 768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  level,
  input  logic        level_valid,
`ifdef SETTINGS_CUSTOM_EN
  input  logic [4:0]  custom_num,
  input  logic [6:0]  custom_size,
  output logic        settings_err,
`endif
  game_set_if.master  out,
  output logic        settings_valid,
  output logic        busy
);

  localparam logic [11:0] HRes = 12'(H_RES);
  localparam logic [11:0] VRes = 12'(V_RES);

  typedef enum logic [2:0] {StIdle, StLoad, StMul, StCenter, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  lvl_q;
  logic [4:0]  num_q;
  logic [6:0]  size_q;
  logic [11:0] acc_q;
  logic [2:0]  bit_q;
  logic [10:0] xpos_q, ypos_q;
  logic        err_q;
  logic        valid_q;
  logic        req_ok;
  logic [11:0] diff_x, diff_y;

`ifdef SETTINGS_CUSTOM_EN
  logic [4:0]  cnum_q;
  logic [6:0]  csize_q;
  logic        err_out_q;
  assign req_ok       = level_valid;
  assign settings_err = err_out_q;
`else
  assign req_ok       = level_valid && (level != 2'd0);
`endif

  assign busy           = (state_q != StIdle);
  assign settings_valid = valid_q;
  assign diff_x         = HRes - {2'b00, acc_q[9:0]};
  assign diff_y         = VRes - {2'b00, acc_q[9:0]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests are only seen in idle, so anything arriving while busy is dropped
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_ok) state_d = StLoad;
      StLoad:   state_d = StMul;
      StMul:    if (bit_q == 3'd6) state_d = StCenter;
      StCenter: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Working datapath: request capture, multiplier, centring
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q  <= 2'd0;
      num_q  <= 5'd0;
      size_q <= 7'd0;
      acc_q  <= 12'd0;
      bit_q  <= 3'd0;
      xpos_q <= 11'd0;
      ypos_q <= 11'd0;
      err_q  <= 1'b0;
`ifdef SETTINGS_CUSTOM_EN
      cnum_q  <= 5'd0;
      csize_q <= 7'd0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_ok) begin
            lvl_q <= level;
`ifdef SETTINGS_CUSTOM_EN
            cnum_q  <= custom_num;
            csize_q <= custom_size;
`endif
          end
        end
        StLoad: begin
          acc_q <= 12'd0;
          bit_q <= 3'd0;
          case (lvl_q)
            2'd1: begin num_q <= 5'd8;  size_q <= 7'd64; end
            2'd2: begin num_q <= 5'd12; size_q <= 7'd48; end
            2'd3: begin num_q <= 5'd16; size_q <= 7'd40; end
            default: begin
`ifdef SETTINGS_CUSTOM_EN
              num_q  <= cnum_q;
              size_q <= csize_q;
`else
              num_q  <= 5'd0;
              size_q <= 7'd0;
`endif
            end
          endcase
        end
        StMul: begin
          if (size_q[bit_q]) begin
            acc_q <= acc_q + ({7'd0, num_q} << bit_q);
          end
          bit_q <= bit_q + 3'd1;
        end
        StCenter: begin
          xpos_q <= diff_x[11:1];
          ypos_q <= diff_y[11:1];
`ifdef SETTINGS_CUSTOM_EN
          // Full 12-bit product is compared so an oversize board cannot alias below V_RES
          err_q <= (acc_q > VRes) || (num_q == 5'd0) || (size_q == 7'd0);
`else
          err_q <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  // Output registers change only on the DONE edge so the latch always sees a coherent set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out.button_num  <= 5'd0;
      out.button_size <= 7'd0;
      out.board_size  <= 10'd0;
      out.board_xpos  <= 11'd0;
      out.board_ypos  <= 11'd0;
      valid_q         <= 1'b0;
`ifdef SETTINGS_CUSTOM_EN
      err_out_q       <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
`ifdef SETTINGS_CUSTOM_EN
      err_out_q <= 1'b0;
`endif
      if (state_q == StDone) begin
        if (!err_q) begin
          out.button_num  <= num_q;
          out.button_size <= size_q;
          out.board_size  <= acc_q[9:0];
          out.board_xpos  <= xpos_q;
          out.board_ypos  <= ypos_q;
          valid_q         <= 1'b1;
        end
`ifdef SETTINGS_CUSTOM_EN
        else begin
          err_out_q <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_settings_gen.sv
// Directed bench for settings_gen: presets, busy/strobe timing, dropped requests,
// mid-calculation reset and (with SETTINGS_CUSTOM_EN) custom requests.
module tb_settings_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] level = 2'd0;
  logic       level_valid = 1'b0;
  logic [4:0] custom_num = 5'd0;
  logic [6:0] custom_size = 7'd0;
  logic       settings_err;
  logic       settings_valid;
  logic       busy;
  int         n_cmp = 0;
  int         n_bad = 0;

  game_set_if gs ();

  settings_gen #(.H_RES(1024), .V_RES(768)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .level          (level),
    .level_valid    (level_valid),
`ifdef SETTINGS_CUSTOM_EN
    .custom_num     (custom_num),
    .custom_size    (custom_size),
    .settings_err   (settings_err),
`endif
    .out            (gs),
    .settings_valid (settings_valid),
    .busy           (busy)
  );

`ifndef SETTINGS_CUSTOM_EN
  assign settings_err = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int n, input int s, input int b,
                         input int x, input int y);
    chk({tag, ".num"},   32'(gs.button_num),  n);
    chk({tag, ".size"},  32'(gs.button_size), s);
    chk({tag, ".board"}, 32'(gs.board_size),  b);
    chk({tag, ".xpos"},  32'(gs.board_xpos),  x);
    chk({tag, ".ypos"},  32'(gs.board_ypos),  y);
  endtask

  // Drive one request on edge N; return at the negedge after edge N
  task automatic request(input logic [1:0] lvl);
    @(negedge clk);
    level       = lvl;
    level_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    level_valid = 1'b0;
  endtask

  // Edges N+1..N+9 busy with no strobe, then the strobe on N+10 and its drop on N+11
  task automatic run_to_done(input string tag);
    chk({tag, ".busyN"}, 32'(busy), 1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (settings_valid !== 1'b0 || busy !== 1'b1) begin
        chk({tag, ".early"}, {30'd0, busy, settings_valid}, 32'd2);
      end
    end
    @(negedge clk);
    chk({tag, ".valid10"}, 32'(settings_valid), 1);
    chk({tag, ".busy10"},  32'(busy), 0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst.valid", 32'(settings_valid), 0);
    chk("rst.busy",  32'(busy), 0);
    chk("rst.err",   32'(settings_err), 0);
    chk_out("rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Presets
    request(2'd1);
    run_to_done("easy");
    chk_out("easy", 8, 64, 512, 256, 128);
    @(negedge clk);
    chk("easy.valid11", 32'(settings_valid), 0);

    request(2'd2);
    run_to_done("med");
    chk_out("med", 12, 48, 576, 224, 96);
    @(negedge clk);
    chk("med.valid11", 32'(settings_valid), 0);

    request(2'd3);
    run_to_done("hard");
    chk_out("hard", 16, 40, 640, 192, 64);
    @(negedge clk);
    chk("hard.valid11", 32'(settings_valid), 0);

`ifndef SETTINGS_CUSTOM_EN
    // level 0 is not a request without the custom feature
    request(2'd0);
    chk("lvl0.busy", 32'(busy), 0);
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0 || settings_valid !== 1'b0) chk("lvl0.idle", {30'd0, busy, settings_valid}, 0);
    end
    chk_out("lvl0", 16, 40, 640, 192, 64);
`endif

    // Pulses at N+3 and N+10 of a medium request are dropped
    request(2'd2);
    repeat (2) @(negedge clk);
    level = 2'd3; level_valid = 1'b1;          // sampled at N+3
    @(negedge clk);
    level_valid = 1'b0;
    repeat (6) @(negedge clk);                  // now after edge N+9
    level = 2'd1; level_valid = 1'b1;          // sampled at N+10 (DONE edge)
    @(negedge clk);
    level_valid = 1'b0;
    chk("drop.valid10", 32'(settings_valid), 1);
    chk_out("drop", 12, 48, 576, 224, 96);
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0 || settings_valid !== 1'b0) chk("drop.quiet", {30'd0, busy, settings_valid}, 0);
    end
    chk("drop.busy", 32'(busy), 0);

    // Reset in the middle of an easy request
    request(2'd1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst.busy", 32'(busy), 0);
    chk_out("mrst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) begin
      @(negedge clk);
      if (busy !== 1'b0 || settings_valid !== 1'b0) chk("mrst.quiet", {30'd0, busy, settings_valid}, 0);
    end
    chk("mrst.valid", 32'(settings_valid), 0);

`ifdef SETTINGS_CUSTOM_EN
    // Oversize custom board: error strobe, outputs untouched
    request(2'd2);
    run_to_done("pre");
    custom_num = 5'd20; custom_size = 7'd40;
    request(2'd0);
    repeat (9) @(negedge clk);
    chk("cerr.err", 32'(settings_err), 1);
    chk("cerr.valid", 32'(settings_valid), 0);
    chk_out("cerr", 12, 48, 576, 224, 96);
    @(negedge clk);
    chk("cerr.err11", 32'(settings_err), 0);

    custom_num = 5'd10; custom_size = 7'd50;
    request(2'd0);
    run_to_done("cust");
    chk("cust.err", 32'(settings_err), 0);
    chk_out("cust", 10, 50, 500, 262, 134);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
